// File: rtl/dispatch_pkg.sv
// Shared types and default sizing for the go/done job dispatcher.
package dispatch_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} dispatch_state_t;

    localparam int DEF_DEPTH    = 4;
    localparam int DEF_ID_WIDTH = 4;
    localparam int DEF_TIMEOUT  = 255;
endpackage

// File: rtl/job_fifo.sv
// Small register FIFO holding pending job IDs; head is read combinationally.
module job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             push_en, pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_en) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_en) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/go_dispatcher.sv
// Issues queued job IDs to the go/done controller one at a time, with a
// per-job timeout and a one-cycle completion record.
module go_dispatcher
    import dispatch_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ID_WIDTH = DEF_ID_WIDTH,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ID_WIDTH-1:0]      req_id,
    output logic                     go,
    input  logic                     done,
    output logic                     ack,
    output logic                     cpl_valid,
    output logic [ID_WIDTH-1:0]      cpl_id,
    output logic                     cpl_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     stray_done
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    dispatch_state_t     state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                tflag_q, tflag_d;
    logic                stray_q, stray_d;
    logic                fifo_full, fifo_empty;
    logic [ID_WIDTH-1:0] head;

    job_fifo #(.DEPTH(DEPTH), .WIDTH(ID_WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .pop   (state_q == ACK),
        .wdata (req_id),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            tflag_q <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tflag_q <= tflag_d;
            stray_q <= stray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tflag_d = tflag_q;
        stray_d = stray_q | (done && state_q != WAIT_DONE);
        case (state_q)
            IDLE:      if (!fifo_empty) state_d = ISSUE;
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (timer_q != T_MAX) timer_d = timer_q + TW'(1);
                // done wins over a timeout landing in the same cycle
                if (done) begin
                    state_d = ACK;
                    tflag_d = 1'b0;
                end else if (timer_q == T_LAST) begin
                    state_d = ACK;
                    tflag_d = 1'b1;
                end
            end
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign req_ready   = !fifo_full;
    assign go          = (state_q == ISSUE);
    assign ack         = (state_q == ACK);
    assign cpl_valid   = (state_q == ACK);
    assign cpl_id      = (state_q == ACK) ? head : '0;
    assign cpl_timeout = (state_q == ACK) && tflag_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign stray_done  = stray_q;
endmodule

// File: tb/tb_go_dispatcher.sv
// Scenario bench for go_dispatcher with a queue-based reference model.
module tb_go_dispatcher;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int TMO   = 8;

    logic           clk = 1'b0;
    logic           rst, req_valid, req_ready, go, done, ack;
    logic           cpl_valid, cpl_timeout, busy, stray_done;
    logic [IDW-1:0] req_id, cpl_id;
    logic [2:0]     occupancy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    go_dispatcher #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .go(go), .done(done), .ack(ack), .cpl_valid(cpl_valid),
        .cpl_id(cpl_id), .cpl_timeout(cpl_timeout), .busy(busy),
        .occupancy(occupancy), .stray_done(stray_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_go(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (go) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_id = '0; done = 1'b0;
        tick(); tick();
        checks++; if ({go, ack, cpl_valid, cpl_timeout, busy, stray_done} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {go, ack, cpl_valid, cpl_timeout, busy, stray_done});
        end
        checks++; if (occupancy !== 3'd0 || req_ready !== 1'b1 || cpl_id !== 4'd0) begin
            errors++; $display("FAIL reset_fifo: occ=%0d ready=%b id=%0d want 0/1/0", occupancy, req_ready, cpl_id);
        end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || go !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b go=%b want 0/0", busy, go);
        end
    endtask

    task automatic test_single;
        int gos;
        req_valid = 1'b1; req_id = 4'd3;
        tick();
        req_valid = 1'b0;
        checks++; if (occupancy !== 3'd1 || go !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_n1: occ=%0d go=%b busy=%b want 1/0/1", occupancy, go, busy);
        end
        tick();
        checks++; if (go !== 1'b1) begin
            errors++; $display("FAIL single_go_n2: go=%b want 1", go);
        end
        gos = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (go || ack) gos++;
        end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gos !== 0) begin
            errors++; $display("FAIL single_quiet: extra go/ack=%0d want 0", gos);
        end
        checks++; if ({ack, cpl_valid, cpl_timeout} !== 3'b110 || cpl_id !== 4'd3) begin
            errors++; $display("FAIL single_cpl: ack/v/to=%b id=%0d want 110 id=3", {ack, cpl_valid, cpl_timeout}, cpl_id);
        end
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b0 || stray_done !== 1'b0) begin
            errors++; $display("FAIL single_after: ack=%b busy=%b stray=%b want 000", ack, busy, stray_done);
        end
    endtask

    task automatic test_timeout;
        bit found;
        int n;
        req_valid = 1'b1; req_id = 4'd7;
        tick();
        req_valid = 1'b0;
        wait_go(found);
        checks++; if (!found) begin
            errors++; $display("FAIL timeout_go: go never seen");
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack) break;
            n++;
        end
        checks++; if (n !== TMO) begin
            errors++; $display("FAIL timeout_len: wait cycles=%0d want %0d", n, TMO);
        end
        checks++; if (cpl_valid !== 1'b1 || cpl_id !== 4'd7 || cpl_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_cpl: v=%b id=%0d to=%b want 1/7/1", cpl_valid, cpl_id, cpl_timeout);
        end
        tick();
    endtask

    task automatic test_simul;
        bit found;
        req_valid = 1'b1; req_id = 4'd12;
        tick();
        req_valid = 1'b0;
        wait_go(found);
        checks++; if (!found) begin
            errors++; $display("FAIL simul_go: go never seen");
        end
        repeat (TMO) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (ack !== 1'b1 || cpl_timeout !== 1'b0 || cpl_id !== 4'd12) begin
            errors++; $display("FAIL simul_cpl: ack=%b to=%b id=%0d want 1/0/12", ack, cpl_timeout, cpl_id);
        end
        tick();
        checks++; if (stray_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL simul_after: stray=%b busy=%b want 0/0", stray_done, busy);
        end
    endtask

    task automatic test_fill;
        int q[$];
        int got[$];
        int next_id = 1;
        bit held = 1'b0;
        bit pop;
        for (int c = 0; c < 90; c++) begin
            req_valid = (next_id <= 5);
            req_id = IDW'(next_id);
            checks++; if (occupancy !== 3'(q.size()) || req_ready !== (q.size() < DEPTH)) begin
                errors++; $display("FAIL fill_occ: occ=%0d ready=%b want %0d/%b", occupancy, req_ready, q.size(), q.size() < DEPTH);
            end
            if (req_valid && !req_ready && next_id == 5) held = 1'b1;
            pop = 1'b0;
            if (cpl_valid) begin
                checks++; if (q.size() == 0 || cpl_id !== IDW'(q[0]) || cpl_timeout !== 1'b1) begin
                    errors++; $display("FAIL fill_cpl: id=%0d to=%b want head/1", cpl_id, cpl_timeout);
                end
                got.push_back(int'(cpl_id));
                pop = 1'b1;
            end
            if (req_valid && q.size() < DEPTH) begin
                q.push_back(next_id);
                next_id++;
            end
            if (pop && q.size() > 0) void'(q.pop_front());
            tick();
        end
        req_valid = 1'b0;
        checks++; if (!held) begin
            errors++; $display("FAIL fill_backpressure: ID 5 never held off");
        end
        checks++; if (got.size() !== 5) begin
            errors++; $display("FAIL fill_count: completions=%0d want 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== i + 1) begin
                errors++; $display("FAIL fill_order: slot %0d id=%0d want %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_random;
        int q[$];
        int done_at = -1, exp_cpl = -1, ncpl = 0, d;
        bit inflight = 1'b0, exp_to = 1'b0, pop;
        for (int c = 0; c < 700; c++) begin
            req_valid = (c < 400) && ($urandom_range(0, 2) != 0);
            req_id = IDW'($urandom_range(0, 15));
            done = (c == done_at);
            checks++; if (occupancy !== 3'(q.size()) || req_ready !== (q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_occ: c=%0d occ=%0d ready=%b want %0d", c, occupancy, req_ready, q.size());
            end
            if (go) begin
                checks++; if (inflight) begin
                    errors++; $display("FAIL rand_go: c=%0d go while job in flight", c);
                end
                inflight = 1'b1;
                d = $urandom_range(1, TMO + 3);
                if (d <= TMO) begin
                    done_at = c + d; exp_cpl = c + d + 1; exp_to = 1'b0;
                end else begin
                    done_at = -1; exp_cpl = c + TMO + 1; exp_to = 1'b1;
                end
            end
            pop = 1'b0;
            if (cpl_valid) begin
                checks++; if (c !== exp_cpl || q.size() == 0 || cpl_id !== IDW'(q[0]) || cpl_timeout !== exp_to) begin
                    errors++; $display("FAIL rand_cpl: c=%0d id=%0d to=%b want c=%0d to=%b", c, cpl_id, cpl_timeout, exp_cpl, exp_to);
                end
                inflight = 1'b0;
                ncpl++;
                pop = 1'b1;
            end
            if (req_valid && q.size() < DEPTH) q.push_back(int'(req_id));
            if (pop && q.size() > 0) void'(q.pop_front());
            tick();
        end
        req_valid = 1'b0; done = 1'b0;
        checks++; if (q.size() != 0 || busy !== 1'b0 || ncpl < 10 || stray_done !== 1'b0) begin
            errors++; $display("FAIL rand_drain: left=%0d busy=%b cpl=%0d stray=%b", q.size(), busy, ncpl, stray_done);
        end
    endtask

    task automatic test_stray;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (stray_done !== 1'b1 || ack !== 1'b0) begin
            errors++; $display("FAIL stray_set: stray=%b ack=%b want 1/0", stray_done, ack);
        end
        repeat (3) tick();
        checks++; if (stray_done !== 1'b1 || cpl_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_sticky: stray=%b cpl=%b busy=%b want 1/0/0", stray_done, cpl_valid, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (stray_done !== 1'b0) begin
            errors++; $display("FAIL stray_clear: stray=%b want 0", stray_done);
        end
    endtask

    task automatic test_reset_mid;
        int gos = 0, cpls = 0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_id = IDW'(9 + i);
            tick();
        end
        req_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || occupancy !== 3'd3 || go !== 1'b0) begin
            errors++; $display("FAIL rmid_pre: busy=%b occ=%0d go=%b want 1/3/0", busy, occupancy, go);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || occupancy !== 3'd0 || ack !== 1'b0 || cpl_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_flush: busy=%b occ=%0d ack=%b cpl=%b want 0/0/0/0", busy, occupancy, ack, cpl_valid);
        end
        for (int i = 0; i < 30; i++) begin
            if (go) gos++;
            if (cpl_valid) cpls++;
            tick();
        end
        checks++; if (gos !== 0 || cpls !== 0) begin
            errors++; $display("FAIL rmid_quiet: go=%0d cpl=%0d want 0/0", gos, cpls);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_simul();
        test_fill();
        test_random();
        test_stray();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
